// File: rtl/paddle_pos_filter_pkg.sv
// Shared types and defaults for the paddle position filter.
package paddle_pkg;

    localparam int unsigned ADC_W_DEF = 12;
    localparam int unsigned POS_W_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SCALE  = 2'd1,
        ST_UPDATE = 2'd2
    } post_state_e;

    // Paddle column used after reset.
    function automatic int unsigned pos_centre(input int unsigned pos_max);
        return pos_max / 2;
    endfunction

endpackage

// File: rtl/paddle_pos_filter_if.sv
// ADC sample stream in, paddle position out.
interface paddle_pos_filter_if #(
    parameter int unsigned ADC_W = paddle_pkg::ADC_W_DEF,
    parameter int unsigned POS_W = paddle_pkg::POS_W_DEF
);
    logic             enable;
    logic [ADC_W-1:0] adc_result;
    logic             adc_valid;
    logic [POS_W-1:0] pos;
    logic             pos_valid;
    logic             busy;

    modport master (output enable, adc_result, adc_valid, input pos, pos_valid, busy);
    modport slave  (input enable, adc_result, adc_valid, output pos, pos_valid, busy);
endinterface

// File: rtl/paddle_pos_filter_sample_averager.sv
// Box-car accumulator: sums 2^AVG_LOG2 accepted samples and strobes the mean.
module sample_averager #(
    parameter int unsigned ADC_W    = 12,
    parameter int unsigned AVG_LOG2 = 3
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable_i,
    input  logic [ADC_W-1:0] sample_i,
    input  logic             sample_valid_i,
    output logic [ADC_W-1:0] avg_o,
    output logic             avg_valid_o
);
    localparam int unsigned ACC_W = ADC_W + AVG_LOG2;

    logic [ACC_W-1:0]    acc_q, acc_d, sum_c;
    logic [AVG_LOG2-1:0] cnt_q, cnt_d;
    logic [ADC_W-1:0]    avg_q, avg_d;
    logic                avg_valid_q, avg_valid_d;

    // Disabled clears the partial window; the last sample of a window publishes the mean.
    always_comb begin
        sum_c       = acc_q + ACC_W'(sample_i);
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        avg_d       = avg_q;
        avg_valid_d = 1'b0;
        if (!enable_i) begin
            acc_d = '0;
            cnt_d = '0;
        end else if (sample_valid_i) begin
            if (cnt_q == '1) begin
                avg_d       = sum_c[ACC_W-1:AVG_LOG2];
                acc_d       = '0;
                cnt_d       = '0;
                avg_valid_d = 1'b1;
            end else begin
                acc_d = sum_c;
                cnt_d = cnt_q + AVG_LOG2'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            acc_q       <= '0;
            cnt_q       <= '0;
            avg_q       <= '0;
            avg_valid_q <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            avg_q       <= avg_d;
            avg_valid_q <= avg_valid_d;
        end
    end

    assign avg_o       = avg_q;
    assign avg_valid_o = avg_valid_q;
endmodule

// File: rtl/paddle_pos_filter.sv
// Averages ADC samples, scales to a paddle column and applies dead-band hysteresis.
// Define PADDLE_INVERT_EN to mirror the column (reversed pot wiring).
module paddle_pos_filter
    import paddle_pkg::*;
#(
    parameter int unsigned ADC_W    = ADC_W_DEF,
    parameter int unsigned AVG_LOG2 = 3,
    parameter int unsigned POS_W    = POS_W_DEF,
    parameter int unsigned POS_MAX  = 239,
    parameter int unsigned DEADBAND = 2
) (
    input  logic                clk,
    input  logic                reset_n,
    paddle_pos_filter_if.slave  bus
);
    localparam int unsigned PROD_W = ADC_W + POS_W + 1;
    localparam int unsigned SCL_W  = POS_W + 1;

    if (AVG_LOG2 < 2 || AVG_LOG2 > 6) begin : g_bad_avg_log2
        $error("AVG_LOG2 must be in 2..6");
    end
    if (POS_MAX >= (1 << POS_W)) begin : g_bad_pos_max
        $error("POS_MAX does not fit POS_W");
    end

    logic [ADC_W-1:0]  avg;
    logic              avg_valid;
    post_state_e       state_q, state_d;
    logic [POS_W-1:0]  scaled_q, scaled_d;
    logic [POS_W-1:0]  pos_q, pos_d;
    logic              pos_valid_q, pos_valid_d;
    logic              busy_q, busy_d;
    logic              first_q, first_d;
    logic              enable_q;
    logic [PROD_W-1:0] prod_c;
    logic [SCL_W-1:0]  scl_c;
    logic [POS_W-1:0]  clamp_c, target_c, diff_c;
    logic              move_c;

    sample_averager #(
        .ADC_W    (ADC_W),
        .AVG_LOG2 (AVG_LOG2)
    ) u_avg (
        .clk            (clk),
        .reset_n        (reset_n),
        .enable_i       (bus.enable),
        .sample_i       (bus.adc_result),
        .sample_valid_i (bus.adc_valid),
        .avg_o          (avg),
        .avg_valid_o    (avg_valid)
    );

    // Scale, clamp, optional mirror, and dead-band decision.
    always_comb begin
        prod_c  = PROD_W'(avg) * PROD_W'(POS_MAX + 1);
        scl_c   = SCL_W'(prod_c >> ADC_W);
        clamp_c = (scl_c > SCL_W'(POS_MAX)) ? POS_W'(POS_MAX) : scl_c[POS_W-1:0];
`ifdef PADDLE_INVERT_EN
        target_c = POS_W'(POS_MAX) - clamp_c;
`else
        target_c = clamp_c;
`endif
        diff_c = (scaled_q >= pos_q) ? (scaled_q - pos_q) : (pos_q - scaled_q);
        move_c = first_q || (diff_c > POS_W'(DEADBAND));
    end

    always_ff @(posedge clk) begin
        if (!reset_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (avg_valid) state_d = ST_SCALE;
            ST_SCALE:  state_d = ST_UPDATE;
            ST_UPDATE: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Enable rising edge re-arms the first-update bypass, overriding a same-cycle clear.
    always_comb begin
        scaled_d    = scaled_q;
        pos_d       = pos_q;
        pos_valid_d = 1'b0;
        first_d     = first_q;
        case (state_q)
            ST_SCALE: scaled_d = target_c;
            ST_UPDATE: begin
                if (move_c) begin
                    pos_d       = scaled_q;
                    pos_valid_d = 1'b1;
                    first_d     = 1'b0;
                end
            end
            default: ;
        endcase
        if (bus.enable && !enable_q) first_d = 1'b1;
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            scaled_q    <= '0;
            pos_q       <= POS_W'(pos_centre(POS_MAX));
            pos_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            first_q     <= 1'b1;
            enable_q    <= 1'b0;
        end else begin
            scaled_q    <= scaled_d;
            pos_q       <= pos_d;
            pos_valid_q <= pos_valid_d;
            busy_q      <= busy_d;
            first_q     <= first_d;
            enable_q    <= bus.enable;
        end
    end

    assign bus.pos       = pos_q;
    assign bus.pos_valid = pos_valid_q;
    assign bus.busy      = busy_q;
endmodule
